fp_a_entero: RTL and testbench
==============================

// Module: fp_a_entero
// PURPOSE
//  Multi-cycle IEEE-754 single-precision to signed two's-complement integer converter.
//  Counterpart of the FP adder: the adder aligns and normalizes into float format; this
//  block denormalizes a float back to an integer, shifting one bit per clock.
//  Sits between the FP datapath and integer consumers; start/busy/done handshake.
// PARAMETERS
//  OUT_W   32   integer result width, legal range 16..32
// PORTS
//  clk      in   1      single clock, all state updates on rising edge
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      request; sampled only when busy=0
//  A        in   32     IEEE-754 single operand, captured on accepted start
//  busy     out  1      high from the accepting edge until done
//  done     out  1      one-cycle pulse; Y/invalid/inexact updated on the same edge
//  Y        out  OUT_W  signed integer result, held until next done
//  invalid  out  1      NaN, Inf or out-of-range (saturated result)
//  inexact  out  1      nonzero fraction bits discarded
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, Y=0, invalid=0, inexact=0.
//   Reset mid-conversion aborts: no done is produced, Y returns to 0.
//  FSM IDLE -> SHIFT -> FINISH -> IDLE.
//   IDLE: on start=1, capture A; e=A[30:23]; E=e-127; m={1,A[22:0]} (24b); classify; busy=1.
//   SHIFT: one 1-bit shift per edge while cnt>0, cnt decrements; at cnt=0 -> FINISH.
//   FINISH: round (optional), negate if A[31], saturation check; write Y and flags,
//    pulse done, clear busy, -> IDLE.
//  Shift count N: E>=23 -> left by N=E-23; 0<=E<23 -> right by N=23-E; special cases N=0.
//  Latency: done asserted N+2 cycles after the accepting edge (2..25 for OUT_W=32).
//  Right shifts keep guard bit (last bit out) and sticky (OR of all earlier bits out);
//   inexact = guard|sticky.
//  Special cases (classified in IDLE, N=0):
//   e=255, frac!=0 (NaN)     -> Y=most negative (1<<(OUT_W-1)), invalid=1.
//   e=255, frac=0 (+/-Inf)   -> Y=max positive / most negative, invalid=1.
//   e<127 (zero, denormal, |A|<1) -> Y=0, inexact=(A[30:0]!=0).
//   E>=OUT_W-1 -> saturate by sign, invalid=1; exception: A == -2^(OUT_W-1) exactly
//    -> Y=1<<(OUT_W-1), invalid=0.
//  Magnitude register is max(24,OUT_W)+1 bits wide; a rounding carry reaching 2^(OUT_W-1)
//   saturates if positive (invalid=1), is exact if negative.
//  -0.0 -> Y=0, flags 0. invalid and inexact are never set together except by rounding
//   carry into positive saturation (then invalid=1, inexact=1).
//  start while busy=1 is ignored (no queueing). start held high after done -> a new
//   conversion is accepted on the edge after done.
// CONFIGURATION
//  ROUND_NEAREST_EN defined: FINISH applies round-to-nearest-even on the magnitude
//   (increment if guard & (sticky | lsb)). Latency unchanged.
//  ROUND_NEAREST_EN undefined: truncation toward zero (C cast semantics); no round logic.
//  Denormal/|A|<1 rule under ROUND_NEAREST_EN: 0.5<|A|<1 -> +/-1; |A|=0.5 -> 0.
// TESTING
//  (OUT_W=32; latency counted in cycles from the accepting edge to done)
//  A=0x40490FDB (pi): Y=3, inexact=1, invalid=0, done at 24 cycles (N=22).
//  A=0xC2F6E979 (-123.456): Y=0xFFFFFF85, inexact=1; same with ROUND_NEAREST_EN.
//  A=0x4B800001 (16777218): Y=0x01000002, inexact=0, done at 3 cycles (left shift N=1).
//  A=0x4F000000 -> Y=0x7FFFFFFF, invalid=1; A=0xCF000000 -> Y=0x80000000, invalid=0;
//   both done at 2 cycles.
//  A=0x7FC00000 -> Y=0x80000000, invalid=1; A=0x00000001 -> Y=0, inexact=1, invalid=0;
//   A=0x80000000 -> Y=0, flags 0.
//  A=0x3FC00000 (1.5) / 0x40200000 (2.5): truncation -> 1 / 2; ROUND_NEAREST_EN -> 2 / 2.
//   Pulse start during busy -> ignored, exactly one done.
//   rst_n low mid-SHIFT -> no done, Y=0.

Source files
------------

// File: rtl/fp_a_entero.sv
// Multi-cycle IEEE-754 single to signed integer converter, one shift bit per clock.
// Optional macro ROUND_NEAREST_EN selects round-to-nearest-even (default: truncate toward zero).
`timescale 1ns/1ps
module fp_a_entero #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      A,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] Y,
  output logic             invalid,
  output logic             inexact
);
  // state    | meaning
  // S_IDLE   | waiting for start; operand captured and classified on accept
  // S_SHIFT  | one-bit denormalizing shift per clock until cnt reaches 0
  // S_FINISH | round, negate, saturate; write result and pulse done
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

  localparam int               MW      = ((OUT_W > 24) ? OUT_W : 24) + 1;
  localparam logic [OUT_W-1:0] Y_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] Y_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [MW-1:0]    MAG_LIM = MW'(1) << (OUT_W-1);
  localparam logic [7:0]       E_SAT   = 8'(126 + OUT_W);

  state_t           r_state, w_next;
  logic             r_sign, r_left, r_spec, r_spec_inv, r_spec_inx;
  logic [OUT_W-1:0] r_spec_y;
  logic [MW-1:0]    r_mag;
  logic             r_guard, r_sticky;
  logic [4:0]       r_cnt;
  logic             r_done, r_inv, r_inx;
  logic [OUT_W-1:0] r_y;

  logic [7:0]       w_exp;
  logic [22:0]      w_frac;
  logic             w_left;
  logic [4:0]       w_cnt;
  logic             w_spec, w_spec_inv, w_spec_inx;
  logic [OUT_W-1:0] w_spec_y;
  logic [MW-1:0]    w_mag_fin;
  logic             w_pos_ovf;
  logic [OUT_W-1:0] w_y_norm;

  assign w_exp  = A[30:23];
  assign w_frac = A[22:0];
  assign w_left = (w_exp >= 8'd150);
  // Low five bits of e-150 / 150-e; the normal range keeps the distance below 32.
  assign w_cnt  = w_left ? (w_exp[4:0] - 5'd22) : (5'd22 - w_exp[4:0]);

  always_comb begin
    w_spec     = 1'b1;
    w_spec_y   = '0;
    w_spec_inv = 1'b0;
    w_spec_inx = 1'b0;
    if (w_exp == 8'hFF) begin
      w_spec_inv = 1'b1;
      w_spec_y   = (A[31] || (w_frac != '0)) ? Y_MIN : Y_MAX;
    end else if (w_exp < 8'd127) begin
      w_spec_inx = |A[30:0];
`ifdef ROUND_NEAREST_EN
      if ((w_exp == 8'd126) && (w_frac != '0))
        w_spec_y = A[31] ? '1 : OUT_W'(1);
`endif
    end else if (w_exp >= E_SAT) begin
      if (A[31] && (w_exp == E_SAT) && (w_frac == '0)) begin
        w_spec_y = Y_MIN;
      end else begin
        w_spec_inv = 1'b1;
        w_spec_y   = A[31] ? Y_MIN : Y_MAX;
      end
    end else begin
      w_spec = 1'b0;
    end
  end

`ifdef ROUND_NEAREST_EN
  assign w_mag_fin = r_mag + MW'(r_guard & (r_sticky | r_mag[0]));
`else
  assign w_mag_fin = r_mag;
`endif
  assign w_pos_ovf = !r_sign && (w_mag_fin >= MAG_LIM);
  assign w_y_norm  = r_sign ? -w_mag_fin[OUT_W-1:0] : w_mag_fin[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SHIFT;
      S_SHIFT:  if (r_cnt == 5'd0) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign     <= 1'b0;
      r_left     <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_inv <= 1'b0;
      r_spec_inx <= 1'b0;
      r_spec_y   <= '0;
      r_mag      <= '0;
      r_guard    <= 1'b0;
      r_sticky   <= 1'b0;
      r_cnt      <= 5'd0;
      r_done     <= 1'b0;
      r_inv      <= 1'b0;
      r_inx      <= 1'b0;
      r_y        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign     <= A[31];
            r_left     <= w_left;
            r_spec     <= w_spec;
            r_spec_inv <= w_spec_inv;
            r_spec_inx <= w_spec_inx;
            r_spec_y   <= w_spec_y;
            r_mag      <= MW'({1'b1, w_frac});
            r_guard    <= 1'b0;
            r_sticky   <= 1'b0;
            r_cnt      <= w_spec ? 5'd0 : w_cnt;
          end
        end
        S_SHIFT: begin
          if (r_cnt != 5'd0) begin
            r_cnt <= r_cnt - 5'd1;
            if (r_left) begin
              r_mag <= r_mag << 1;
            end else begin
              r_mag    <= r_mag >> 1;
              r_guard  <= r_mag[0];
              r_sticky <= r_sticky | r_guard;
            end
          end
        end
        S_FINISH: begin
          r_done <= 1'b1;
          if (r_spec) begin
            r_y   <= r_spec_y;
            r_inv <= r_spec_inv;
            r_inx <= r_spec_inx;
          end else begin
            r_y   <= w_pos_ovf ? Y_MAX : w_y_norm;
            r_inv <= w_pos_ovf;
            r_inx <= r_guard | r_sticky;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign Y       = r_y;
  assign invalid = r_inv;
  assign inexact = r_inx;

endmodule

// File: tb/tb_fp_a_entero.sv
// Randomized and directed bench for fp_a_entero (OUT_W=32) against a value-level model.
`timescale 1ns/1ps
module tb_fp_a_entero;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a_in;
  logic        busy, done, invalid, inexact;
  logic [31:0] y_out;

  int n_checks = 0;
  int n_fail   = 0;

  fp_a_entero #(.OUT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in),
    .busy(busy), .done(done), .Y(y_out), .invalid(invalid), .inexact(inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Value-level reference: integer part and remainder of mant * 2^(E-23).
  task automatic ref_model(input logic [31:0] a, output logic [31:0] y,
                           output logic inv, output logic inx, output int lat);
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [63:0] mant, ip, rem, half, neg;
    int          ex, k;
    s = a[31]; e = a[30:23]; f = a[22:0];
    y = 32'd0; inv = 1'b0; inx = 1'b0; lat = 2;
    ex = int'(e) - 127;
    if (e == 8'hFF) begin
      inv = 1'b1;
      y = (f != 0 || s) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (e == 8'd0) begin
      inx = (f != 0);
    end else if (ex >= 31) begin
      if (s && ex == 31 && f == 0) y = 32'h8000_0000;
      else begin
        inv = 1'b1;
        y = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else begin
      mant = {41'd0, 1'b1, f};
      if (ex >= 23) begin
        ip = mant << (ex - 23);
        if (ex >= 0) lat = 2 + ex - 23;
      end else begin
        k = 23 - ex;
        if (ex >= 0) lat = 2 + k;
        if (k >= 60) begin
          ip = 64'd0;
          inx = 1'b1;
        end else begin
          ip   = mant >> k;
          rem  = mant - (ip << k);
          half = 64'd1 << (k - 1);
          inx  = (rem != 0);
`ifdef ROUND_NEAREST_EN
          if (rem > half || (rem == half && ip[0])) ip = ip + 64'd1;
`endif
        end
      end
      if (!s && ip >= 64'h8000_0000) begin
        inv = 1'b1;
        y = 32'h7FFF_FFFF;
      end else begin
        neg = -ip;
        y = s ? neg[31:0] : ip[31:0];
      end
    end
  endtask

  task automatic run_conv(input logic [31:0] a);
    logic [31:0] ey;
    logic        ei, ex;
    int          lat, cyc;
    bit          seen;
    ref_model(a, ey, ei, ex, lat);
    @(negedge clk);
    a_in = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val($sformatf("busy_after_accept %h", a), {31'd0, busy}, 32'd1);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    check_val($sformatf("latency %h", a), cyc, lat);
    check_val($sformatf("Y %h", a), y_out, ey);
    check_val($sformatf("invalid %h", a), {31'd0, invalid}, {31'd0, ei});
    check_val($sformatf("inexact %h", a), {31'd0, inexact}, {31'd0, ex});
    check_val($sformatf("busy_at_done %h", a), {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] directed [16] = '{
    32'h40490FDB, 32'hC2F6E979, 32'h4B800001, 32'h4F000000,
    32'hCF000000, 32'h7FC00000, 32'h00000001, 32'h80000000,
    32'h3FC00000, 32'h40200000, 32'h7F800000, 32'hFF800000,
    32'h3F000000, 32'h3F400000, 32'hBF400000, 32'h4EFFFFFF
  };

  initial begin
    int          n_done;
    logic [31:0] r, last_y;
    logic [7:0]  re;
    rst_n = 1'b0; start = 1'b0; a_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_Y", y_out, 32'd0);
    check_val("reset_busy", {31'd0, busy}, 32'd0);
    check_val("reset_done", {31'd0, done}, 32'd0);
    check_val("reset_invalid", {31'd0, invalid}, 32'd0);
    check_val("reset_inexact", {31'd0, inexact}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_conv(directed[i]);

    // pi anchor values independent of the model
    run_conv(32'h40490FDB);
    check_val("pi_Y_const", y_out, 32'd3);
    run_conv(32'hC2F6E979);
    check_val("m123_Y_const", y_out, 32'hFFFF_FF85);

    for (int i = 0; i < 150; i++) begin
      r = $urandom;
      if (i % 3 != 0) begin
        re = 8'($urandom_range(118, 162));
        r[30:23] = re;
        if ($urandom_range(0, 7) == 0) r[19:0] = 20'd0;
      end
      run_conv(r);
    end

    // start pulses while busy must be ignored
    @(negedge clk);
    a_in = 32'h40490FDB; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0; last_y = 32'd0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) begin n_done++; last_y = y_out; end
      if (i == 3 || i == 10) begin start = 1'b1; a_in = 32'h4F000000; end
      else start = 1'b0;
    end
    check_val("ignore_start_ndone", n_done, 1);
    check_val("ignore_start_Y", last_y, 32'd3);

    // reset in the middle of SHIFT aborts the conversion
    @(negedge clk);
    a_in = 32'h40490FDB; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    check_val("abort_Y", y_out, 32'd0);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    n_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check_val("abort_ndone", n_done, 0);

    // start held high re-accepts on the edge after done
    @(negedge clk);
    a_in = 32'h4F000000; start = 1'b1;
    @(posedge clk);
    n_done = 0;
    for (int i = 0; i < 10 && n_done == 0; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check_val("held_first_done", n_done, 1);
    @(posedge clk); #1;
    check_val("held_reaccept_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    check_val("held_second_done", {31'd0, done}, 32'd1);
    check_val("held_second_Y", y_out, 32'h7FFF_FFFF);
    start = 1'b0;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
